// File: rtl/mips_avl_pkg.sv
// Shared types and Avalon-MM width constants for the MIPS bus arbiter.
package mips_avl_pkg;

    localparam int AVL_ADDR_W = 32;
    localparam int AVL_DATA_W = 32;
    localparam int AVL_BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mips_avl_rr_pick.sv
// Combinational two-way picker: round-robin on a tie, or m0-wins when FIXED_PRIORITY is set.
module mips_avl_rr_pick #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] pick
);

    // last = 1 means m1 owned the previous grant, so m0 is next in line on a tie.
    always_comb begin
        pick = 2'b00;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11: begin
                if (FIXED_PRIORITY != 0 || last) begin
                    pick = 2'b01;
                end else begin
                    pick = 2'b10;
                end
            end
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/mips_avl_arbiter.sv
// Two-master Avalon-MM arbiter: one whole transfer per grant, with a sticky slave-stall watchdog.
module mips_avl_arbiter
    import mips_avl_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0,
    parameter int MAX_WAIT       = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AVL_ADDR_W-1:0] m0_address,
    input  logic [AVL_DATA_W-1:0] m0_writedata,
    input  logic [AVL_BE_W-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    output logic [AVL_DATA_W-1:0] m0_readdata,
    output logic                  m0_waitrequest,
    input  logic [AVL_ADDR_W-1:0] m1_address,
    input  logic [AVL_DATA_W-1:0] m1_writedata,
    input  logic [AVL_BE_W-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    output logic [AVL_DATA_W-1:0] m1_readdata,
    output logic                  m1_waitrequest,
    output logic [AVL_ADDR_W-1:0] s_address,
    output logic [AVL_DATA_W-1:0] s_writedata,
    output logic [AVL_BE_W-1:0]   s_byteenable,
    output logic                  s_read,
    output logic                  s_write,
    input  logic [AVL_DATA_W-1:0] s_readdata,
    input  logic                  s_waitrequest,
    output logic                  bus_error,
    output logic [1:0]            grant
);

    localparam logic [15:0] MAX_WAIT_C = 16'(MAX_WAIT);

    arb_state_t  state_q, state_d;
    logic        last_q, last_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        bus_error_q, bus_error_d;

    logic        req0, req1, own_req;
    logic [1:0]  pick;
    logic [15:0] wait_inc;

    assign req0     = m0_read | m0_write;
    assign req1     = m1_read | m1_write;
    assign wait_inc = wait_cnt_q + 16'd1;
    assign own_req  = (state_q == GNT0) ? req0 : ((state_q == GNT1) ? req1 : 1'b0);

    mips_avl_rr_pick #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_pick (
        .req  ({req1, req0}),
        .last (last_q),
        .pick (pick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            wait_cnt_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    // A grant ends on completion, on the owner dropping its request, or on watchdog expiry.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        wait_cnt_d  = wait_cnt_q;
        bus_error_d = bus_error_q;
        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (pick[0]) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (pick[1]) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0, GNT1: begin
                if (!own_req || !s_waitrequest) begin
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_inc;
                    if (wait_inc == MAX_WAIT_C) begin
                        bus_error_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_address      = '0;
        s_writedata    = '0;
        s_byteenable   = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        m0_readdata    = '0;
        m1_readdata    = '0;
        m0_waitrequest = req0;
        m1_waitrequest = req1;
        grant          = 2'b00;
        case (state_q)
            GNT0: begin
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                s_read         = m0_read & ~m0_write;
                s_write        = m0_write;
                m0_readdata    = s_readdata;
                m0_waitrequest = s_waitrequest;
                grant          = 2'b01;
            end
            GNT1: begin
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                s_read         = m1_read & ~m1_write;
                s_write        = m1_write;
                m1_readdata    = s_readdata;
                m1_waitrequest = s_waitrequest;
                grant          = 2'b10;
            end
            default: ;
        endcase
    end

    assign bus_error = bus_error_q;

endmodule

// File: tb/tb_mips_avl_arbiter.sv
// Bench for mips_avl_arbiter: a round-robin/MAX_WAIT=4 copy and a fixed-priority copy share stimulus.
module tb_mips_avl_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] m0Addr = '0, m0Wdata = '0, m1Addr = '0, m1Wdata = '0;
    logic [3:0]  m0Be = '0, m1Be = '0;
    logic        m0Rd = 1'b0, m0Wr = 1'b0, m1Rd = 1'b0, m1Wr = 1'b0;
    logic [31:0] sRdata = '0;
    logic        sWait = 1'b0;

    logic [31:0] m0RdataO [2];
    logic [31:0] m1RdataO [2];
    logic [31:0] sAddrO [2];
    logic [31:0] sWdataO [2];
    logic [3:0]  sBeO [2];
    logic        m0WaitO [2];
    logic        m1WaitO [2];
    logic        sReadO [2];
    logic        sWriteO [2];
    logic        busErrO [2];
    logic [1:0]  grantO [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_avl_arbiter #(.FIXED_PRIORITY(0), .MAX_WAIT(4)) dut0 (
        .clk(clk), .reset(reset),
        .m0_address(m0Addr), .m0_writedata(m0Wdata), .m0_byteenable(m0Be),
        .m0_read(m0Rd), .m0_write(m0Wr), .m0_readdata(m0RdataO[0]), .m0_waitrequest(m0WaitO[0]),
        .m1_address(m1Addr), .m1_writedata(m1Wdata), .m1_byteenable(m1Be),
        .m1_read(m1Rd), .m1_write(m1Wr), .m1_readdata(m1RdataO[0]), .m1_waitrequest(m1WaitO[0]),
        .s_address(sAddrO[0]), .s_writedata(sWdataO[0]), .s_byteenable(sBeO[0]),
        .s_read(sReadO[0]), .s_write(sWriteO[0]), .s_readdata(sRdata), .s_waitrequest(sWait),
        .bus_error(busErrO[0]), .grant(grantO[0])
    );

    mips_avl_arbiter #(.FIXED_PRIORITY(1), .MAX_WAIT(255)) dut1 (
        .clk(clk), .reset(reset),
        .m0_address(m0Addr), .m0_writedata(m0Wdata), .m0_byteenable(m0Be),
        .m0_read(m0Rd), .m0_write(m0Wr), .m0_readdata(m0RdataO[1]), .m0_waitrequest(m0WaitO[1]),
        .m1_address(m1Addr), .m1_writedata(m1Wdata), .m1_byteenable(m1Be),
        .m1_read(m1Rd), .m1_write(m1Wr), .m1_readdata(m1RdataO[1]), .m1_waitrequest(m1WaitO[1]),
        .s_address(sAddrO[1]), .s_writedata(sWdataO[1]), .s_byteenable(sBeO[1]),
        .s_read(sReadO[1]), .s_write(sWriteO[1]), .s_readdata(sRdata), .s_waitrequest(sWait),
        .bus_error(busErrO[1]), .grant(grantO[1])
    );

    // Reference model: owner is -1 when idle, else the granted master index.
    int owner [2];
    bit lastM1 [2];
    int wcnt [2];
    bit err [2];
    bit modelLive = 1'b0;
    int fpPar [2];
    int mwPar [2];

    initial begin
        fpPar[0] = 0;
        fpPar[1] = 1;
        mwPar[0] = 4;
        mwPar[1] = 255;
    end

    always @(posedge clk) begin
        bit r0, r1, ownReq;
        int win;
        r0 = m0Rd | m0Wr;
        r1 = m1Rd | m1Wr;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                owner[i]  = -1;
                lastM1[i] = 1'b1;
                wcnt[i]   = 0;
                err[i]    = 1'b0;
            end else if (owner[i] < 0) begin
                win = -1;
                if (r0 && r1)  win = (fpPar[i] != 0 || lastM1[i]) ? 0 : 1;
                else if (r0)   win = 0;
                else if (r1)   win = 1;
                if (win >= 0) begin
                    owner[i]  = win;
                    lastM1[i] = (win == 1);
                    wcnt[i]   = 0;
                end
            end else begin
                ownReq = (owner[i] == 0) ? r0 : r1;
                if (!ownReq || !sWait) begin
                    owner[i] = -1;
                end else begin
                    wcnt[i] = wcnt[i] + 1;
                    if (wcnt[i] >= mwPar[i]) begin
                        err[i]   = 1'b1;
                        owner[i] = -1;
                    end
                end
            end
        end
        if (reset) modelLive = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Per-cycle comparison of every output of both arbiters against the model.
    always @(negedge clk) begin
        logic [31:0] eAddr, eWdata;
        logic [3:0]  eBe;
        logic        eRead, eWrite;
        logic [1:0]  eGrant;
        if (modelLive) begin
            for (int i = 0; i < 2; i++) begin
                eAddr = '0; eWdata = '0; eBe = '0; eRead = 1'b0; eWrite = 1'b0; eGrant = 2'b00;
                if (owner[i] == 0) begin
                    eAddr = m0Addr; eWdata = m0Wdata; eBe = m0Be;
                    eRead = m0Rd & ~m0Wr; eWrite = m0Wr; eGrant = 2'b01;
                end else if (owner[i] == 1) begin
                    eAddr = m1Addr; eWdata = m1Wdata; eBe = m1Be;
                    eRead = m1Rd & ~m1Wr; eWrite = m1Wr; eGrant = 2'b10;
                end
                checkOutput($sformatf("dut%0d grant", i), {30'd0, grantO[i]}, {30'd0, eGrant});
                checkOutput($sformatf("dut%0d s_address", i), sAddrO[i], eAddr);
                checkOutput($sformatf("dut%0d s_writedata", i), sWdataO[i], eWdata);
                checkOutput($sformatf("dut%0d s_byteenable", i), {28'd0, sBeO[i]}, {28'd0, eBe});
                checkOutput($sformatf("dut%0d s_read", i), {31'd0, sReadO[i]}, {31'd0, eRead});
                checkOutput($sformatf("dut%0d s_write", i), {31'd0, sWriteO[i]}, {31'd0, eWrite});
                checkOutput($sformatf("dut%0d m0_waitrequest", i), {31'd0, m0WaitO[i]},
                            {31'd0, (owner[i] == 0) ? sWait : (m0Rd | m0Wr)});
                checkOutput($sformatf("dut%0d m1_waitrequest", i), {31'd0, m1WaitO[i]},
                            {31'd0, (owner[i] == 1) ? sWait : (m1Rd | m1Wr)});
                checkOutput($sformatf("dut%0d m0_readdata", i), m0RdataO[i], (owner[i] == 0) ? sRdata : 32'd0);
                checkOutput($sformatf("dut%0d m1_readdata", i), m1RdataO[i], (owner[i] == 1) ? sRdata : 32'd0);
                checkOutput($sformatf("dut%0d bus_error", i), {31'd0, busErrO[i]}, {31'd0, err[i]});
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int m, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        if (m == 0) begin
            m0Rd = rd; m0Wr = wr; m0Addr = addr; m0Wdata = data; m0Be = be;
        end else begin
            m1Rd = rd; m1Wr = wr; m1Addr = addr; m1Wdata = data; m1Be = be;
        end
    endtask

    task automatic setSlave(input logic waitReq, input logic [31:0] rdata);
        sWait  = waitReq;
        sRdata = rdata;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        setSlave(0, 0);
        nextCycle();
        reset = 1'b0;
    endtask

    int g0Exp [11];
    int g1Exp [11];
    int swTab [8];

    initial begin
        g0Exp = '{0, 1, 0, 2, 0, 1, 0, 2, 0, 2, 0};
        g1Exp = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 2, 0};
        swTab = '{0, 1, 1, 1, 0, 0, 0, 0};

        $display("[TB] start");
        nextCycle();

        // Single master, zero-wait read.
        doReset();
        applyStimulus(0, 1, 0, 32'hBFC00000, 32'h0, 4'hF);
        setSlave(0, 32'h12345678);
        @(negedge clk);
        checkOutput("s1 c0 grant", {30'd0, grantO[0]}, 32'd0);
        checkOutput("s1 c0 m0_wait", {31'd0, m0WaitO[0]}, 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("s1 c1 grant", {30'd0, grantO[0]}, 32'd1);
        checkOutput("s1 c1 m0_readdata", m0RdataO[0], 32'h12345678);
        checkOutput("s1 c1 m0_wait", {31'd0, m0WaitO[0]}, 32'd0);
        checkOutput("s1 c1 s_address", sAddrO[0], 32'hBFC00000);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("s1 c2 grant", {30'd0, grantO[0]}, 32'd0);
        checkOutput("s1 c2 s_read", {31'd0, sReadO[0]}, 32'd0);

        // Both masters continuously: RR alternates, fixed priority starves m1 until m0 drops.
        doReset();
        applyStimulus(0, 1, 0, 32'h00000100, 32'h0, 4'hF);
        applyStimulus(1, 0, 1, 32'h00001000, 32'hDEADBEEF, 4'hF);
        setSlave(0, 32'hA5A5A5A5);
        for (int c = 0; c < 11; c++) begin
            if (c == 8)  applyStimulus(0, 0, 0, 0, 0, 0);
            if (c == 10) applyStimulus(1, 0, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput($sformatf("s2 c%0d rr grant", c), {30'd0, grantO[0]}, g0Exp[c]);
            checkOutput($sformatf("s2 c%0d fixed grant", c), {30'd0, grantO[1]}, g1Exp[c]);
            if (c < 3) checkOutput($sformatf("s2 c%0d m1_wait", c), {31'd0, m1WaitO[0]}, 32'd1);
            if (c == 3) checkOutput("s2 c3 s_writedata", sWdataO[0], 32'hDEADBEEF);
            nextCycle();
        end

        // Slave wait states on an m1 write while m0 is held off.
        doReset();
        applyStimulus(1, 0, 1, 32'h00002000, 32'hCAFEF00D, 4'h3);
        for (int c = 0; c < 8; c++) begin
            if (c == 1) applyStimulus(0, 1, 0, 32'h00003000, 32'h0, 4'hF);
            if (c == 5) applyStimulus(1, 0, 0, 0, 0, 0);
            if (c == 7) applyStimulus(0, 0, 0, 0, 0, 0);
            setSlave(swTab[c][0], 32'h0BADF00D);
            @(negedge clk);
            checkOutput($sformatf("s4 c%0d s_write", c), {31'd0, sWriteO[0]}, (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
            if (c >= 1 && c <= 5) checkOutput($sformatf("s4 c%0d m0_wait", c), {31'd0, m0WaitO[0]}, 32'd1);
            if (c == 4) checkOutput("s4 c4 m1_wait", {31'd0, m1WaitO[0]}, 32'd0);
            if (c == 6) checkOutput("s4 c6 grant", {30'd0, grantO[0]}, 32'd1);
            nextCycle();
        end

        // Both strobes from one master, then an abort while the slave waits.
        doReset();
        applyStimulus(1, 1, 1, 32'h00005000, 32'h11112222, 4'hF);
        setSlave(0, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("s6 c1 s_write", {31'd0, sWriteO[0]}, 32'd1);
        checkOutput("s6 c1 s_read", {31'd0, sReadO[0]}, 32'd0);
        nextCycle();
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 32'h00006000, 32'h0, 4'hF);
        setSlave(1, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("s6 c3 s_read", {31'd0, sReadO[0]}, 32'd1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("s6 c4 grant", {30'd0, grantO[0]}, 32'd1);
        checkOutput("s6 c4 s_read", {31'd0, sReadO[0]}, 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("s6 c5 grant", {30'd0, grantO[0]}, 32'd0);

        // Watchdog expiry with MAX_WAIT=4, then reset during a fresh grant.
        doReset();
        applyStimulus(0, 1, 0, 32'h00004000, 32'h0, 4'hF);
        setSlave(1, 32'h77777777);
        for (int c = 0; c < 7; c++) begin
            if (c == 6) reset = 1'b1;
            @(negedge clk);
            if (c >= 1 && c <= 4) checkOutput($sformatf("s5 c%0d grant", c), {30'd0, grantO[0]}, 32'd1);
            if (c == 4) checkOutput("s5 c4 bus_error", {31'd0, busErrO[0]}, 32'd0);
            if (c == 5) begin
                checkOutput("s5 c5 bus_error", {31'd0, busErrO[0]}, 32'd1);
                checkOutput("s5 c5 grant", {30'd0, grantO[0]}, 32'd0);
            end
            if (c == 6) checkOutput("s5 c6 grant", {30'd0, grantO[0]}, 32'd1);
            nextCycle();
        end
        reset = 1'b0;
        @(negedge clk);
        checkOutput("s5 rst grant", {30'd0, grantO[0]}, 32'd0);
        checkOutput("s5 rst bus_error", {31'd0, busErrO[0]}, 32'd0);
        checkOutput("s5 rst s_read", {31'd0, sReadO[0]}, 32'd0);
        checkOutput("s5 rst m0_readdata", m0RdataO[0], 32'd0);
        checkOutput("s5 rst fixed grant", {30'd0, grantO[1]}, 32'd0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        setSlave(0, 32'h0);
        nextCycle();
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
